// File: rtl/divu_seq.sv
// Sequential unsigned restoring divider: one quotient bit per clock, start/rdy/valid handshake.
// Optional result self-check (chk_err port) enabled by defining DIVU_SELFCHECK_EN.
module divu_seq #(
  parameter int X_WIDTH = 4,
  parameter int Y_WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [X_WIDTH-1:0] x,
  input  logic [Y_WIDTH-1:0] y,
  output logic               rdy,
  output logic               valid,
  output logic [X_WIDTH-1:0] q,
  output logic [Y_WIDTH-1:0] r,
  output logic               dbz
`ifdef DIVU_SELFCHECK_EN
  ,
  output logic               chk_err
`endif
);

  localparam int CW = $clog2(X_WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [X_WIDTH-1:0] xs_q, xs_d;
  logic [Y_WIDTH-1:0] ys_q, ys_d;
  logic [Y_WIDTH:0]   pr_q, pr_d;
  logic [X_WIDTH-1:0] quo_q, quo_d;
  logic [Y_WIDTH-1:0] rem_q, rem_d;
  logic               dbz_q, dbz_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [Y_WIDTH:0]   pr_sh, pr_nx;
  logic [X_WIDTH-1:0] quo_nx;
  logic               ge;

`ifdef DIVU_SELFCHECK_EN
  localparam int XY = X_WIDTH + Y_WIDTH;
  logic [X_WIDTH-1:0] xl_q, xl_d;
  logic               chk_q, chk_d;
  logic [XY-1:0]      prod;
`endif

  // One restoring step: bring in the next dividend bit, subtract divisor if it fits.
  always_comb begin
    pr_sh  = {pr_q[Y_WIDTH-1:0], xs_q[X_WIDTH-1]};
    ge     = (pr_sh >= {1'b0, ys_q});
    pr_nx  = ge ? (pr_sh - {1'b0, ys_q}) : pr_sh;
    quo_nx = {quo_q[X_WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    pr_d    = pr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;
`ifdef DIVU_SELFCHECK_EN
    xl_d    = xl_q;
    chk_d   = chk_q;
    prod    = XY'(quo_nx) * XY'(ys_q) + XY'(pr_nx[Y_WIDTH-1:0]);
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
`ifdef DIVU_SELFCHECK_EN
          xl_d  = x;
          chk_d = 1'b0;
`endif
          if (y != '0) begin
            state_d = S_RUN;
            xs_d    = x;
            ys_d    = y;
            pr_d    = '0;
            quo_d   = '0;
            rem_d   = '0;
            dbz_d   = 1'b0;
            cnt_d   = CW'(X_WIDTH);
          end else begin
            state_d = S_DONE;
            quo_d   = '1;
            rem_d   = '0;
            dbz_d   = 1'b1;
          end
        end
      end
      S_RUN: begin
        xs_d  = {xs_q[X_WIDTH-2:0], 1'b0};
        pr_d  = pr_nx;
        quo_d = quo_nx;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          rem_d   = pr_nx[Y_WIDTH-1:0];
          dbz_d   = 1'b0;
`ifdef DIVU_SELFCHECK_EN
          chk_d   = (prod != XY'(xl_q));
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      pr_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef DIVU_SELFCHECK_EN
      xl_q    <= '0;
      chk_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      pr_q    <= pr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
`ifdef DIVU_SELFCHECK_EN
      xl_q    <= xl_d;
      chk_q   <= chk_d;
`endif
    end
  end

  assign rdy   = (state_q != S_RUN);
  assign valid = (state_q == S_DONE);
  assign q     = quo_q;
  assign r     = rem_q;
  assign dbz   = dbz_q;
`ifdef DIVU_SELFCHECK_EN
  assign chk_err = chk_q;
`endif

endmodule

// File: doc/divu_seq.md
Name: divu_seq

Overview:
- Sequential unsigned restoring divider; the inverse of the team's combinational unsigned multiplier.
- Takes an X_WIDTH dividend and a Y_WIDTH divisor and produces an X_WIDTH quotient and a Y_WIDTH remainder, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic cluster.
- Driven by a start/rdy/valid handshake from the top-level controller.

Parameters:
X_WIDTH, 4, dividend and quotient width (>=2)
Y_WIDTH, 2, divisor and remainder width (>=1, <=X_WIDTH)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, synchronous, active-high
start  input  1  request; sampled only when rdy=1
x  input  X_WIDTH  dividend, captured on accepted start
y  input  Y_WIDTH  divisor, captured on accepted start
rdy  output  1  block can accept start (IDLE or DONE)
valid  output  1  q/r/dbz hold a completed result
q  output  X_WIDTH  quotient
r  output  Y_WIDTH  remainder
dbz  output  1  last result was divide-by-zero

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values, applied at the next edge with rst=1 in any state, including mid-RUN:
  - state=IDLE, rdy=1, valid=0, q=0, r=0, dbz=0.
  - Any in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE (rdy=1, valid=0):
  - start=1 with y!=0 -> RUN; latch x, y; clear partial remainder (Y_WIDTH+1 bits); load count=X_WIDTH.
  - start=1 with y==0 -> DONE next edge; q=all ones, r=0, dbz=1.
- RUN (rdy=0, valid=0), once per edge:
  - pr = {pr[Y_WIDTH-1:0], xs[MSB]}; shift xs left.
  - If pr >= {0,y}: pr -= y, shift 1 into q. Else shift 0 into q.
  - Decrement count. On the edge where count reaches 0 -> DONE; r = pr[Y_WIDTH-1:0], dbz=0.
  - start is ignored in RUN.
- DONE (rdy=1, valid=1):
  - q/r/dbz held stable indefinitely.
  - start=1 behaves as in IDLE: accepted; valid drops on that edge; the new op begins (back-to-back, no bubble).
  - No start -> stay in DONE.
- Latency: start high in cycle 0 -> valid high from cycle X_WIDTH+1 (5 for default). Divide-by-zero: valid from cycle 1.
- q/r during RUN are internal working values and not observable as results. Outputs are meaningful only when valid=1.
- Invariant when valid=1 and dbz=0: q*y + r == x, r < y.
- x/y changing while not accepted has no effect.

Optional Feature:
- Macro: DIVU_SELFCHECK_EN.
- Defined:
  - Adds output port chk_err (1 bit, reset 0).
  - On entry to DONE with dbz=0, compute q*y+r at X_WIDTH+Y_WIDTH bits against the latched x.
  - chk_err=1 on mismatch; held with valid and cleared on next accepted start or rst.
  - dbz results never set chk_err.
- Undefined: port and checker logic absent; all other behaviour identical.

Test Plan:
- Reset, then start with x=13, y=3 in cycle 0 -> rdy=0 cycles 1-4; cycle 5: valid=1, q=4, r=1, dbz=0, rdy=1.
- x=15, y=1 -> q=15, r=0 after 5 cycles. Then x=0, y=3 started in the DONE cycle -> valid drops next cycle, later q=0, r=0.
- Divide by zero: x=9, y=0 -> cycle 1: valid=1, q=15, r=0, dbz=1. Next op x=6, y=2 -> q=3, r=0, dbz=0.
- start pulsed each cycle during RUN with different x/y -> ignored; result matches the first accepted op (x=14, y=3 -> q=4, r=2).
- rst asserted in cycle 2 of RUN -> next cycle rdy=1, valid=0, q=0, r=0. A fresh op x=7, y=2 -> q=3, r=1.
- Exhaustive sweep of all 16x4 x/y pairs against the reference model; with DIVU_SELFCHECK_EN, chk_err stays 0 throughout.
